ace_vram_arbiter: RTL and testbench
===================================

Name: ace_vram_arbiter

Overview:
- Single-port BRAM arbiter for the Ace screen/character RAM, sharing one memory port between the video fetcher and the Z80 bus.
- Sits between fpga_ace's video scanner and CPU decode and the BRAM; runs on the clkram (75 MHz) domain.
- Video has absolute priority with fixed latency; the CPU is stalled via a wait output until its access completes.

Parameters:
- ADDR_W, 10, memory address width (1 KB bank).
- DATA_W, 8, data width.

Ports:
- clk  in  1  arbiter/BRAM clock (clkram).
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  single-cycle video fetch request.
- vid_addr  in  ADDR_W  video fetch address, sampled with vid_req.
- vid_data  out  DATA_W  fetched video byte.
- vid_valid  out  1  vid_data valid, one-cycle pulse.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req.
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  access complete, one-cycle pulse.
- cpu_wait  out  1  combinational: cpu_req & ~cpu_ack (to Z80 WAIT logic).
- mem_addr  out  ADDR_W  BRAM address (registered).
- mem_we  out  1  BRAM write enable (registered).
- mem_wdata  out  DATA_W  BRAM write data (registered).
- mem_rdata  in  DATA_W  BRAM read data, one-cycle latency after mem_addr.

Behaviour:
- Reset: all outputs 0 (mem_addr, mem_wdata, vid_data, cpu_rdata = 0; mem_we, vid_valid, cpu_ack = 0). CPU FSM goes to C_IDLE. In-flight video pipeline flags are cleared. A reset mid-operation drops pending accesses: no vid_valid, no cpu_ack.
- Slot selection, at each edge T, for the memory cycle T+1:
  - if vid_req: video owns the slot; mem_addr <= vid_addr; mem_we <= 0.
  - else if CPU FSM is in C_IDLE and cpu_req: CPU owns the slot; mem_addr <= cpu_addr; mem_we <= cpu_we; mem_wdata <= cpu_wdata. FSM goes to C_ISSUE.
  - else: slot idle; mem_we <= 0; mem_addr holds its previous value.
- Video timing is fixed regardless of CPU activity:
  - req sampled at T; BRAM data valid in T+2; vid_data captured at edge T+2; vid_valid high during T+3.
  - Back-to-back vid_req (every cycle) is legal and fully pipelined, three deep.
- CPU FSM: C_IDLE -> C_ISSUE (slot owned) -> C_READ (mem_rdata valid; captured into cpu_rdata for reads, held for writes) -> C_ACK (cpu_ack = 1 for exactly one cycle) -> C_IDLE.
  - A vid_req never blocks an already-granted CPU access; it only delays the grant.
  - Unstalled CPU latency: cpu_ack in the 3rd cycle after the grant edge.
  - A new grant is possible at the C_IDLE edge following C_ACK, so cpu_req held high yields one access per 4 cycles minimum.
- Simultaneous vid_req and cpu_req at the same edge: video wins; CPU is granted at the first later edge with vid_req = 0.
- Continuous vid_req starves the CPU indefinitely; the fetcher guarantees gaps.
- Write semantics: mem_we is asserted for exactly one cycle (C_ISSUE). A read issued the cycle after a write to the same address returns the new data (BRAM read-after-write).
- cpu_rdata holds its value until the next CPU read completes. vid_data holds its value until the next video capture.

Optional Feature:
- Macro ACE_ARB_STATS_EN.
- Defined: adds output stall_count (16 bits). It increments each cycle cpu_req & ~cpu_ack and the slot went to video, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset: assert reset for 2 cycles mid CPU read -> cpu_ack never pulses, all outputs 0, FSM idle; first request after release completes normally.
- Lone video fetch: BRAM[0x123] = 0x5A, vid_req at T with vid_addr = 0x123 -> vid_valid only in T+3, vid_data = 0x5A.
- CPU write then read: write 0x3C to 0x040, ack at grant+3; then read 0x040 -> cpu_rdata = 0x3C with cpu_ack; cpu_wait high from req until the ack cycle.
- Collision: cpu_req (read 0x010) and vid_req (0x200) at the same edge, vid_req repeating for 5 cycles -> video returns at T+3..T+7; CPU grant at the first edge without vid_req; ack 3 cycles later; with ACE_ARB_STATS_EN, stall_count = 5.
- Back-to-back video: vid_req every cycle for addresses 0..7 -> 8 consecutive vid_valid pulses with matching data, no CPU grant during the run.
- Held cpu_req, two reads at 0x001 and 0x002 (addr changed after ack) -> two acks 4 cycles apart with correct data.

Source files
------------

// File: rtl/ace_vram_arbiter.sv
// ace_vram_arbiter
//   Single-port BRAM arbiter for the Ace screen/character RAM (clkram domain).
//   Video fetches have absolute priority and a fixed three-stage latency; the
//   Z80 side runs a small FSM and is stalled through cpu_wait until its access
//   has been acknowledged.
//
// Ports
//   clk, reset                 arbiter/BRAM clock, synchronous active-high reset
//   vid_req/vid_addr           single-cycle video fetch request and address
//   vid_data/vid_valid         fetched byte, valid for one cycle (req edge + 3)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata
//                              level CPU request, held stable until cpu_ack
//   cpu_rdata/cpu_ack          read data and one-cycle completion pulse
//   cpu_wait                   cpu_req & ~cpu_ack, to Z80 WAIT logic
//   mem_addr/mem_we/mem_wdata  registered BRAM port controls
//   mem_rdata                  BRAM read data, one cycle after mem_addr
//
// Optional feature
//   ACE_ARB_STATS_EN: adds output stall_count[15:0], a saturating count of
//   cycles in which a waiting CPU lost the slot to video.
module ace_vram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ACE_ARB_STATS_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;
  localparam logic [1:0] C_ACK   = 2'd3;

  logic [1:0] cpu_state;
  logic       cpu_is_wr;
  // vid_p1: address on the BRAM port; vid_p2: BRAM data for that fetch on mem_rdata
  logic       vid_p1;
  logic       vid_p2;
  logic       cpu_grant;

  assign cpu_grant = ~vid_req & cpu_req & (cpu_state == C_IDLE);
  assign cpu_wait  = cpu_req & ~cpu_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_state <= C_IDLE;
      cpu_is_wr <= 1'b0;
      vid_p1    <= 1'b0;
      vid_p2    <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      vid_p1    <= vid_req;
      vid_p2    <= vid_p1;
      vid_valid <= vid_p2;
      if (vid_p2) vid_data <= mem_rdata;

      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      if (vid_req) begin
        mem_addr <= vid_addr;
      end else if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end

      // Once granted, the CPU sequence runs to completion; video only
      // competes for the address port, which the BRAM has already sampled.
      case (cpu_state)
        C_IDLE: begin
          if (cpu_grant) begin
            cpu_state <= C_ISSUE;
            cpu_is_wr <= cpu_we;
          end
        end
        C_ISSUE: cpu_state <= C_READ;
        C_READ: begin
          if (!cpu_is_wr) cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          cpu_state <= C_ACK;
        end
        default: cpu_state <= C_IDLE;
      endcase
    end
  end

`ifdef ACE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (cpu_wait && vid_req && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ace_vram_arbiter.sv
// Directed bench for ace_vram_arbiter with a behavioural 1 KB BRAM
// (one-cycle registered read, read-first). Memory initialised to
// addr[7:0] ^ 8'hA5, except 0x123 which holds 8'h5A.
module tb_ace_vram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic [7:0] vid_data;
  logic       vid_valid;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       cpu_wait;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef ACE_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  ace_vram_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_wait  (cpu_wait),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ACE_ARB_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " mem_we"},    32'(mem_we),    32'h0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, " vid_data"},  32'(vid_data),  32'h0);
    check({tag, " vid_valid"}, 32'(vid_valid), 32'h0);
    check({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    check({tag, " cpu_ack"},   32'(cpu_ack),   32'h0);
    check({tag, " cpu_wait"},  32'(cpu_wait),  32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    mem[10'h123] = 8'h5A;
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Power-on reset
    step(); step(); step();
    check_zero("por");
`ifdef ACE_ARB_STATS_EN
    check("por stall", 32'(stall_count), 32'h0);
`endif
    reset = 1'b0;
    step();

    // Lone video fetch of 0x123
    vid_req = 1'b1; vid_addr = 10'h123;
    step();
    vid_req = 1'b0; vid_addr = 10'h3FF;
    check("vid1 mem_addr", 32'(mem_addr), 32'h123);
    check("vid1 valid t1", 32'(vid_valid), 32'h0);
    step();
    check("vid1 valid t2", 32'(vid_valid), 32'h0);
    step();
    check("vid1 valid t3", 32'(vid_valid), 32'h1);
    check("vid1 data t3",  32'(vid_data),  32'h5A);
    step();
    check("vid1 valid t4", 32'(vid_valid), 32'h0);
    check("vid1 hold",     32'(vid_data),  32'h5A);

    // CPU write 0x3C to 0x040
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h040; cpu_wdata = 8'h3C;
    #1 check("wr wait req", 32'(cpu_wait), 32'h1);
    step();
    check("wr mem_we",    32'(mem_we),    32'h1);
    check("wr mem_addr",  32'(mem_addr),  32'h040);
    check("wr mem_wdata", 32'(mem_wdata), 32'h3C);
    check("wr ack g1",    32'(cpu_ack),   32'h0);
    step();
    check("wr we g2",     32'(mem_we),    32'h0);
    check("wr ack g2",    32'(cpu_ack),   32'h0);
    check("wr wait g2",   32'(cpu_wait),  32'h1);
    step();
    check("wr ack g3",    32'(cpu_ack),   32'h1);
    check("wr wait g3",   32'(cpu_wait),  32'h0);
    check("wr rdata hold", 32'(cpu_rdata), 32'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    check("wr ack g4",    32'(cpu_ack),   32'h0);

    // CPU read back 0x040
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h040;
    step(); step();
    check("rd ack g2",    32'(cpu_ack),   32'h0);
    step();
    check("rd ack g3",    32'(cpu_ack),   32'h1);
    check("rd rdata",     32'(cpu_rdata), 32'h3C);
    cpu_req = 1'b0;
    step();

    // Collision: CPU read 0x010 vs five video fetches of 0x200
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    vid_req = 1'b1; vid_addr = 10'h200;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("col valid c%0d", i), 32'(vid_valid), 32'((i >= 3) && (i <= 7)));
      if ((i >= 3) && (i <= 7)) check($sformatf("col vdata c%0d", i), 32'(vid_data), 32'hA5);
      check($sformatf("col ack c%0d", i), 32'(cpu_ack), 32'(i == 8));
      if (i == 5) vid_req = 1'b0;
      if (i == 6) check("col mem_addr grant", 32'(mem_addr), 32'h010);
      if (i == 8) begin
        check("col rdata", 32'(cpu_rdata), 32'hB5);
        cpu_req = 1'b0;
      end
    end
`ifdef ACE_ARB_STATS_EN
    check("col stall", 32'(stall_count), 32'd5);
`endif

    // Back-to-back video 0..7 while the CPU waits to read 0x005
    cpu_req = 1'b1; cpu_addr = 10'h005;
    vid_req = 1'b1; vid_addr = 10'h000;
    for (int j = 1; j <= 11; j++) begin
      step();
      if (j < 8) vid_addr = 10'(j);
      else vid_req = 1'b0;
      check($sformatf("b2b we c%0d", j), 32'(mem_we), 32'h0);
      if (j <= 8) check($sformatf("b2b addr c%0d", j), 32'(mem_addr), 32'(j - 1));
      if (j == 9) check("b2b cpu addr", 32'(mem_addr), 32'h005);
      check($sformatf("b2b valid c%0d", j), 32'(vid_valid), 32'((j >= 3) && (j <= 10)));
      if ((j >= 3) && (j <= 10)) check($sformatf("b2b vdata c%0d", j), 32'(vid_data), 32'(pat(j - 3)));
      check($sformatf("b2b ack c%0d", j), 32'(cpu_ack), 32'(j == 11));
      if (j == 11) begin
        check("b2b rdata", 32'(cpu_rdata), 32'hA0);
        cpu_req = 1'b0;
      end
    end
`ifdef ACE_ARB_STATS_EN
    check("b2b stall", 32'(stall_count), 32'd13);
`endif
    step();

    // Held cpu_req: reads of 0x001 then 0x002, acks four cycles apart
    cpu_req = 1'b1; cpu_addr = 10'h001;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("held ack c%0d", i), 32'(cpu_ack), 32'((i == 3) || (i == 7)));
      if (i == 3) begin
        check("held rdata1", 32'(cpu_rdata), 32'hA4);
        cpu_addr = 10'h002;
      end
      if (i == 7) begin
        check("held rdata2", 32'(cpu_rdata), 32'hA7);
        cpu_req = 1'b0;
      end
    end

    // Reset in the middle of a video fetch and a CPU read
    vid_req = 1'b1; vid_addr = 10'h100;
    step();
    vid_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = 10'h003;
    step();
    reset = 1'b1; cpu_req = 1'b0;
    step();
    check_zero("rst1");
    step();
    check_zero("rst2");
`ifdef ACE_ARB_STATS_EN
    check("rst stall", 32'(stall_count), 32'h0);
`endif
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("post rst valid c%0d", i), 32'(vid_valid), 32'h0);
      check($sformatf("post rst ack c%0d", i),   32'(cpu_ack),   32'h0);
    end
    cpu_req = 1'b1; cpu_addr = 10'h003;
    step(); step();
    check("post rst ack g2", 32'(cpu_ack), 32'h0);
    step();
    check("post rst ack g3", 32'(cpu_ack),   32'h1);
    check("post rst rdata",  32'(cpu_rdata), 32'hA6);
    cpu_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
